// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lends one external combinational ALU to two requesters.
// Latency: accept at edge N, response valid sampled at edge N+SETTLE+1; issue interval SETTLE+2.
// Backpressure: one op in flight; requests wait in IDLE, and a stalled response holds the block in RESP.
module alu_arbiter #(
  parameter int WIDTH  = 8,
  parameter int OPW    = 4,
  parameter int SETTLE = 1,
  parameter int CNTW   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_s,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic [CNTW-1:0]  ops_done
);

  // Settle counter only needs to hold SETTLE-1.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]    state;
  logic          owner;
  logic          last_grant;
  logic [CW-1:0] cnt;
  logic          grant0;
  logic          grant1;
  logic          rsp_hs;

  // Grant selection: a sole requester always wins; on a tie the one not served last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = (state == ST_RESP) && !owner;
  assign rsp1_valid = (state == ST_RESP) && owner;
  assign busy       = (state != ST_IDLE);
  assign rsp_hs     = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  // Main FSM: accept an operation, hold it on the ALU for SETTLE cycles, return the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_s      <= '0;
      rsp_data   <= '0;
      ops_done   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant0) begin
            alu_a      <= req0_a;
            alu_b      <= req0_b;
            alu_s      <= req0_op;
            owner      <= 1'b0;
            last_grant <= 1'b0;
            cnt        <= CW'(SETTLE - 1);
            state      <= ST_EXEC;
          end else if (grant1) begin
            alu_a      <= req1_a;
            alu_b      <= req1_b;
            alu_s      <= req1_op;
            owner      <= 1'b1;
            last_grant <= 1'b1;
            cnt        <= CW'(SETTLE - 1);
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt == '0) begin
            rsp_data <= alu_result;
            state    <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          // Returning to IDLE here means a new grant can only happen next cycle.
          if (rsp_hs) begin
            ops_done <= ops_done + 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with an adder standing in for the ALU.
// Main instance uses default parameters; a second instance uses SETTLE=3, CNTW=2.
// Expected responses are queued at request acceptance and compared at response handshake.
module tb_alu_arbiter;

  logic clk;
  logic rst;

  // main instance
  logic       r0v, r0rdy, r1v, r1rdy, p0v, p1v, s0r, s1r, busy;
  logic [7:0] r0a, r0b, r1a, r1b, rdat, alu_a, alu_b, alu_res;
  logic [3:0] r0op, r1op, alu_s;
  logic [15:0] ops;

  // SETTLE=3, CNTW=2 instance
  logic       x_r0v, x_r0rdy, x_r1v, x_r1rdy, x_p0v, x_p1v, x_s0r, x_s1r, x_busy;
  logic [7:0] x_r0a, x_r0b, x_r1a, x_r1b, x_rdat, x_alu_a, x_alu_b, x_alu_res;
  logic [3:0] x_r0op, x_r1op, x_alu_s;
  logic [1:0] x_ops;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nrsp = 0;
  int rsp_cyc = 0;
  int x_acc_cyc = 0;
  int x_rsp_cyc = 0;
  bit saw_p1 = 0;
  int base;

  logic [8:0] exp_q[$];
  int         grant_q[$];
  int         gcyc_q[$];

  assign alu_res   = alu_a + alu_b;
  assign x_alu_res = x_alu_a + x_alu_b;

  alu_arbiter u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_ready(r0rdy), .req0_a(r0a), .req0_b(r0b), .req0_op(r0op),
    .req1_valid(r1v), .req1_ready(r1rdy), .req1_a(r1a), .req1_b(r1b), .req1_op(r1op),
    .rsp0_valid(p0v), .rsp0_ready(s0r), .rsp1_valid(p1v), .rsp1_ready(s1r),
    .rsp_data(rdat), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_result(alu_res), .busy(busy), .ops_done(ops)
  );

  alu_arbiter #(.SETTLE(3), .CNTW(2)) u_alt (
    .clk(clk), .rst(rst),
    .req0_valid(x_r0v), .req0_ready(x_r0rdy), .req0_a(x_r0a), .req0_b(x_r0b), .req0_op(x_r0op),
    .req1_valid(x_r1v), .req1_ready(x_r1rdy), .req1_a(x_r1a), .req1_b(x_r1b), .req1_op(x_r1op),
    .rsp0_valid(x_p0v), .rsp0_ready(x_s0r), .rsp1_valid(x_p1v), .rsp1_ready(x_s1r),
    .rsp_data(x_rdat), .alu_a(x_alu_a), .alu_b(x_alu_b), .alu_s(x_alu_s),
    .alu_result(x_alu_res), .busy(x_busy), .ops_done(x_ops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes at the falling edge, then step past the rising edge.
  task automatic cycle();
    logic [8:0] e;
    logic [7:0] s;
    @(negedge clk);
    if (!rst) begin
      chk("rsp_exclusive", {31'b0, p0v & p1v}, 32'd0);
      if (p1v) saw_p1 = 1;
      if (r0v && r0rdy) begin
        s = r0a + r0b;
        exp_q.push_back({1'b0, s});
        grant_q.push_back(0);
        gcyc_q.push_back(cyc);
      end
      if (r1v && r1rdy) begin
        s = r1a + r1b;
        exp_q.push_back({1'b1, s});
        grant_q.push_back(1);
        gcyc_q.push_back(cyc);
      end
      if ((p0v && s0r) || (p1v && s1r)) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_owner", {31'b0, p1v}, {31'b0, e[8]});
          chk("rsp_data", {24'b0, rdat}, {24'b0, e[7:0]});
        end
        nrsp++;
        rsp_cyc = cyc;
      end
      if (x_r0v && x_r0rdy) x_acc_cyc = cyc;
      if (x_p0v && x_s0r) x_rsp_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_rsp(input int target, input int budget, input string tag);
    for (int k = 0; k < budget && nrsp < target; k++) cycle();
    chk(tag, nrsp, target);
  endtask

  task automatic alt_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                        input int exp_ops);
    logic [7:0] sum;
    sum = a + b;
    x_r0v = 1; x_r0a = a; x_r0b = b; x_r0op = op; x_s0r = 1;
    #1 chk("alt_ready", {31'b0, x_r0rdy}, 32'd1);
    cycle();
    x_r0v = 0;
    for (int k = 0; k < 20 && !x_p0v; k++) begin
      chk("alt_hold_a", {24'b0, x_alu_a}, {24'b0, a});
      chk("alt_hold_b", {24'b0, x_alu_b}, {24'b0, b});
      chk("alt_hold_s", {28'b0, x_alu_s}, {28'b0, op});
      cycle();
    end
    chk("alt_rsp_valid", {31'b0, x_p0v}, 32'd1);
    chk("alt_data", {24'b0, x_rdat}, {24'b0, sum});
    cycle();
    chk("alt_latency", x_rsp_cyc - x_acc_cyc, 32'd4);
    chk("alt_ops", {30'b0, x_ops}, exp_ops);
  endtask

  task automatic clear_q();
    exp_q.delete();
    grant_q.delete();
    gcyc_q.delete();
  endtask

  initial begin
    rst = 1;
    r0v = 0; r0a = 0; r0b = 0; r0op = 0; r1v = 0; r1a = 0; r1b = 0; r1op = 0; s0r = 0; s1r = 0;
    x_r0v = 0; x_r0a = 0; x_r0b = 0; x_r0op = 0; x_r1v = 0; x_r1a = 0; x_r1b = 0; x_r1op = 0;
    x_s0r = 0; x_s1r = 0;
    cycle(); cycle();
    rst = 0;

    // Reset state
    chk("rst_ready0", {31'b0, r0rdy}, 32'd0);
    chk("rst_ready1", {31'b0, r1rdy}, 32'd0);
    chk("rst_rsp0", {31'b0, p0v}, 32'd0);
    chk("rst_rsp1", {31'b0, p1v}, 32'd0);
    chk("rst_data", {24'b0, rdat}, 32'd0);
    chk("rst_alu", {12'b0, alu_a, alu_b, alu_s}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ops", {16'b0, ops}, 32'd0);
    chk("rst_alt_ops", {30'b0, x_ops}, 32'd0);

    // Single request from requester 0
    saw_p1 = 0;
    r0v = 1; r0a = 8'h7E; r0b = 8'h5F; r0op = 4'h0; s0r = 1;
    #1 chk("t1_ready0", {31'b0, r0rdy}, 32'd1);
    chk("t1_ready1", {31'b0, r1rdy}, 32'd0);
    cycle();
    r0v = 0;
    chk("t1_alu_a", {24'b0, alu_a}, 32'h7E);
    chk("t1_alu_b", {24'b0, alu_b}, 32'h5F);
    chk("t1_alu_s", {28'b0, alu_s}, 32'h0);
    chk("t1_busy", {31'b0, busy}, 32'd1);
    wait_rsp(1, 10, "t1_rsp_count");
    chk("t1_latency", rsp_cyc - gcyc_q[0], 32'd2);
    chk("t1_ops", {16'b0, ops}, 32'd1);
    chk("t1_no_rsp1", {31'b0, saw_p1}, 32'd0);
    chk("t1_alu_kept", {24'b0, alu_a}, 32'h7E);

    // Both requesters contend from reset
    rst = 1; cycle(); rst = 0;
    clear_q();
    base = nrsp;
    r0v = 1; r0a = 8'h01; r0b = 8'h02; r1v = 1; r1a = 8'h03; r1b = 8'h04; s0r = 1; s1r = 1;
    for (int k = 0; k < 40 && grant_q.size() < 4; k++) cycle();
    r0v = 0; r1v = 0;
    chk("t2_grants", grant_q.size(), 32'd4);
    for (int i = 0; i < grant_q.size() && i < 4; i++) begin
      chk("t2_order", grant_q[i], i % 2);
      if (i > 0) chk("t2_spacing", gcyc_q[i] - gcyc_q[i-1], 32'd3);
    end
    wait_rsp(base + 4, 30, "t2_rsp_count");

    // Response backpressure on requester 1
    clear_q();
    base = nrsp;
    r1v = 1; r1a = 8'h10; r1b = 8'h20; s1r = 0;
    cycle();
    r1v = 0;
    chk("t3_grant1", grant_q.size(), 32'd1);
    for (int k = 0; k < 10 && !p1v; k++) cycle();
    r0v = 1; r0a = 8'h05; r0b = 8'h06;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_hold_valid", {31'b0, p1v}, 32'd1);
      chk("t3_hold_data", {24'b0, rdat}, 32'h30);
      chk("t3_no_ready0", {31'b0, r0rdy}, 32'd0);
      cycle();
    end
    s1r = 1;
    cycle();
    chk("t3_rsp1_done", nrsp, base + 1);
    cycle();
    r0v = 0;
    chk("t3_grant0", grant_q.size(), 32'd2);
    if (grant_q.size() == 2) chk("t3_grant0_cycle", gcyc_q[1] - rsp_cyc, 32'd1);
    wait_rsp(base + 2, 10, "t3_rsp_count");

    // Reset while a response is pending
    clear_q();
    r0v = 1; r0a = 8'h09; r0b = 8'h09; s0r = 0;
    cycle();
    r0v = 0;
    for (int k = 0; k < 10 && !p0v; k++) cycle();
    chk("t4_pending", {31'b0, p0v}, 32'd1);
    rst = 1;
    cycle();
    rst = 0;
    exp_q.delete();
    chk("t4_rsp0", {31'b0, p0v}, 32'd0);
    chk("t4_rsp1", {31'b0, p1v}, 32'd0);
    chk("t4_busy", {31'b0, busy}, 32'd0);
    chk("t4_data", {24'b0, rdat}, 32'd0);
    chk("t4_alu", {12'b0, alu_a, alu_b, alu_s}, 32'd0);
    chk("t4_ops", {16'b0, ops}, 32'd0);
    base = nrsp;
    grant_q.delete();
    r0v = 1; r0a = 8'h21; r0b = 8'h12; r1v = 1; r1a = 8'h44; r1b = 8'h11; s0r = 1; s1r = 1;
    #1 chk("t4_tie_ready0", {31'b0, r0rdy}, 32'd1);
    chk("t4_tie_ready1", {31'b0, r1rdy}, 32'd0);
    cycle();
    r0v = 0; r1v = 0;
    chk("t4_tie_count", grant_q.size(), 32'd1);
    if (grant_q.size() > 0) chk("t4_tie_first", grant_q[0], 32'd0);
    wait_rsp(base + 1, 10, "t4_rsp_count");
    chk("t4_ops_after", {16'b0, ops}, 32'd1);

    // SETTLE=3 latency and 2-bit counter wrap
    alt_op(8'hFF, 8'h01, 4'h5, 1);
    alt_op(8'h10, 8'h20, 4'h1, 2);
    alt_op(8'h33, 8'h44, 4'h2, 3);
    alt_op(8'h80, 8'h80, 4'h3, 0);
    alt_op(8'h0F, 8'hF0, 4'hA, 1);

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
